// File: rtl/rtc_resp_pkg.sv
// rtc_resp_pkg: register map, bus state encoding and BCD helpers shared by the
// RTC bus responder and its time counter.
package rtc_resp_pkg;
  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  // Returns {carry, next}; a bad ones digit or a value at/above max wraps to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return (v[3:0] > 4'd9 || v >= max) ? 9'h100 :
           {1'b0, (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1};
  endfunction
endpackage

// File: rtl/rtc_bus_responder_if.sv
// rtc_bus_responder_if: multiplexed address/data RTC bus between the control
// path (master) and the device-side responder (slave).
interface rtc_bus_responder_if;
  logic       cs;
  logic       ad;
  logic       rd;
  logic       wr;
  logic [7:0] dat_in;
  logic [7:0] dat_out;
  logic       dat_oe;
  logic       bus_err;
  modport master (output cs, ad, rd, wr, dat_in, input dat_out, dat_oe, bus_err);
  modport slave  (input cs, ad, rd, wr, dat_in, output dat_out, dat_oe, bus_err);
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD SEC/MIN/HOUR chain advanced by tick; any field load
// in a cycle takes priority over that cycle's tick.
module bcd_time_counter
  import rtc_resp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ld_sec,
  input  logic       ld_min,
  input  logic       ld_hour,
  input  logic [7:0] sec_ld,
  input  logic [7:0] min_ld,
  input  logic [7:0] hour_ld,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour
);
  logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [8:0] sec_n, min_n;
  logic       inc;
  always_comb begin
    inc    = tick && !(ld_sec || ld_min || ld_hour);
    sec_n  = bcd_inc(sec_q, SEC_MAX);
    min_n  = bcd_inc(min_q, MIN_MAX);
    sec_d  = ld_sec ? sec_ld : inc ? sec_n[7:0] : sec_q;
    min_d  = ld_min ? min_ld : (inc && sec_n[8]) ? min_n[7:0] : min_q;
    hour_d = ld_hour ? hour_ld :
             (inc && sec_n[8] && min_n[8]) ? 8'(bcd_inc(hour_q, HOUR_MAX)) : hour_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  assign sec  = sec_q;
  assign min  = min_q;
  assign hour = hour_q;
endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: device end of the RTC address/data bus; decodes phases,
// holds the register map, keeps BCD time and returns read data.
module rtc_bus_responder
  import rtc_resp_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter bit ERR_EN   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  rtc_bus_responder_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  logic [1:0]    state_q, state_d;
  logic [7:0]    addr_q, addr_d, wdat_q, wdat_d, ctrl_q, ctrl_d;
  logic [7:0]    day_q, day_d, month_q, month_d, year_q, year_d;
  logic [7:0]    dat_out_q, dat_out_d, rdata, sec, min, hour;
  logic [PW-1:0] presc_q, presc_d;
  logic          dat_oe_q, dat_oe_d, bus_err_q, bus_err_d, pend_q, pend_d;
  logic          cs_q, cs_d, ad_q, ad_d, rd_q, rd_d, wr_q, wr_d;
  logic          act, viol, commit, rd_go, wrap, due, tick;
  always_comb begin
    act  = !bus.cs;
    // ad may only change while neither strobe is held across the change
    viol = act && ((!bus.rd && !bus.wr) || (!bus.rd && !bus.ad) ||
           (!cs_q && bus.ad != ad_q && ((!bus.wr && !wr_q) || (!bus.rd && !rd_q))));
    commit  = act && !viol && state_q == WDATA && bus.wr;
    rd_go   = act && !viol && bus.ad && !bus.rd;
    state_d = (!act || viol) ? IDLE :
              !bus.wr ? (bus.ad ? WDATA : ADDR) :
              rd_go ? RDATA : (state_q == IDLE) ? IDLE : ADDR;
    addr_d  = (act && !viol && !bus.ad && !bus.wr) ? bus.dat_in : addr_q;
    wdat_d  = (act && !viol && bus.ad && !bus.wr) ? bus.dat_in : wdat_q;
    ctrl_d  = (commit && addr_q == ADDR_CTRL)  ? wdat_q : ctrl_q;
    day_d   = (commit && addr_q == ADDR_DAY)   ? wdat_q : day_q;
    month_d = (commit && addr_q == ADDR_MONTH) ? wdat_q : month_q;
    year_d  = (commit && addr_q == ADDR_YEAR)  ? wdat_q : year_q;
    rdata   = addr_q == ADDR_CTRL  ? ctrl_q  :
              addr_q == ADDR_SEC   ? sec     :
              addr_q == ADDR_MIN   ? min     :
              addr_q == ADDR_HOUR  ? hour    :
              addr_q == ADDR_DAY   ? day_q   :
              addr_q == ADDR_MONTH ? month_q :
              addr_q == ADDR_YEAR  ? year_q  : 8'h00;
    dat_out_d = rd_go ? rdata : dat_out_q;
    dat_oe_d  = rd_go;
    bus_err_d = ERR_EN && viol;
    cs_d = bus.cs;
    ad_d = bus.ad;
    rd_d = bus.rd;
    wr_d = bus.wr;
    wrap    = presc_q == PW'(TICK_DIV - 1);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    // a tick colliding with a write commit is carried one cycle later
    due    = (wrap && !ctrl_q[0]) || pend_q;
    tick   = due && !commit;
    pend_d = due && commit;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      wdat_q    <= 8'h00;
      ctrl_q    <= 8'h00;
      day_q     <= 8'h00;
      month_q   <= 8'h00;
      year_q    <= 8'h00;
      dat_out_q <= 8'h00;
      dat_oe_q  <= 1'b0;
      bus_err_q <= 1'b0;
      presc_q   <= '0;
      pend_q    <= 1'b0;
      cs_q      <= 1'b1;
      ad_q      <= 1'b0;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      ctrl_q    <= ctrl_d;
      day_q     <= day_d;
      month_q   <= month_d;
      year_q    <= year_d;
      dat_out_q <= dat_out_d;
      dat_oe_q  <= dat_oe_d;
      bus_err_q <= bus_err_d;
      presc_q   <= presc_d;
      pend_q    <= pend_d;
      cs_q      <= cs_d;
      ad_q      <= ad_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  bcd_time_counter u_time (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .ld_sec  (commit && addr_q == ADDR_SEC),
    .ld_min  (commit && addr_q == ADDR_MIN),
    .ld_hour (commit && addr_q == ADDR_HOUR),
    .sec_ld  (wdat_q),
    .min_ld  (wdat_q),
    .hour_ld (wdat_q),
    .sec     (sec),
    .min     (min),
    .hour    (hour)
  );
  assign bus.dat_out = dat_out_q;
  assign bus.dat_oe  = dat_oe_q;
  assign bus.bus_err = bus_err_q;
endmodule
